generador_patrones: RTL
=======================

GENERADOR_PATRONES -- requirements
Module: generador_patrones

Interface
REQ-001 Parameter PREAMBLE, default 4'b1011: 4-bit frame preamble, sent MSB first.
REQ-002 Parameter GAP_CYCLES, default 2: number of idle cycles after each frame; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  8  payload word, sampled on acceptance.
REQ-006 len_in  input  3  payload length minus one; payload length L = len_in+1, range 1..8.
REQ-007 valid_in  input  1  a frame request is present on data_in/len_in.
REQ-008 ready_out  output  1  block can accept a frame request.
REQ-009 out  output  1  serial line; 0 when not driving frame bits.
REQ-010 out_en  output  1  out carries a valid frame bit this cycle.
REQ-011 busy  output  1  a frame or gap is in progress.
REQ-012 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-013 The FSM SHALL have four states: IDLE, PREAMBLE, PAYLOAD and GAP; the state register is 2 bits or wider.
REQ-014 ready_out SHALL be 1 exactly when the state is IDLE; busy SHALL be the inverse of ready_out.
REQ-015 Acceptance SHALL occur at a rising edge where valid_in=1 and ready_out=1.
- At acceptance: capture data_in and len_in into internal registers.
- Move to PREAMBLE with the bit index at 3.
REQ-016 Inputs SHALL be ignored while ready_out=0; a later change of data_in or len_in SHALL NOT affect a frame already accepted.
REQ-017 PREAMBLE state:
- Lasts 4 cycles.
- out = PREAMBLE[3], [2], [1], [0] in successive cycles; out_en = 1.
- Moves to PAYLOAD with bit index L-1.
REQ-018 PAYLOAD state:
- Lasts L cycles.
- out = captured data bit L-1 down to bit 0, MSB first; out_en = 1.
- Data bits above L-1 are never transmitted.
- After the bit 0 cycle, moves to GAP.
REQ-019 GAP state:
- Lasts GAP_CYCLES cycles with out = 0 and out_en = 0.
- Moves to IDLE after the last gap cycle.
REQ-020 done SHALL be 1 only in the first GAP cycle.
REQ-021 In IDLE, out, out_en and done SHALL be 0.
REQ-022 First frame bit timing:
- First frame bit appears in the cycle immediately after the acceptance edge.
- Total out_en cycles per frame = 4+L.
REQ-023 Back-to-back frames (valid_in held high):
- The next frame is accepted in the first IDLE cycle.
- There are exactly GAP_CYCLES+1 cycles with out_en=0 between the frames.
REQ-024 The gap counter SHALL be 4 bits and the bit index 3 bits; no wrap-around may occur within legal parameter values.
REQ-025 out, out_en and done SHALL be driven from registered state only; there is no combinational path from any input to any output.
REQ-026 Unreachable state encodings SHALL recover to IDLE on the next clock with out = 0.

Reset
REQ-027 When rst=1, the following SHALL apply immediately, regardless of clk:
- State = IDLE.
- out=0, out_en=0, done=0, busy=0, ready_out=1.
- Captured data, length, bit index and gap counter cleared to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first acceptance is possible at the first rising edge after rst deasserts.

Verification
REQ-029 Scenario 1: after reset, hold valid_in=0 for 10 cycles -> ready_out=1, busy=0, out=0, out_en=0 throughout.
REQ-030 Scenario 2: data_in=8'hA5, len_in=7, accepted at edge E0.
- Cycles E0..E11: out = 1,0,1,1,1,0,1,0,0,1,0,1 with out_en=1.
- Cycle E12: done=1.
- Cycle E14: ready_out=1.
REQ-031 Scenario 3: data_in=8'hFE, len_in=0 -> out = 1,0,1,1,0 over 5 out_en cycles; data bits 7..1 never appear.
REQ-032 Scenario 4: valid_in pulsed with data 8'hFF during PAYLOAD of an 8'h00 frame -> no effect; the frame completes with payload zeros and exactly one done pulse.
REQ-033 Scenario 5: valid_in held high with two frames -> exactly 3 out_en=0 cycles between the last payload bit of frame 1 and the first preamble bit of frame 2 (GAP_CYCLES=2).
REQ-034 Scenario 6: rst asserted during payload bit 3 of an 8'hA5 frame -> out=0 and ready_out=1 before the next edge, no done pulse; a new frame after release is transmitted correctly.

Source files
------------

// File: rtl/generador_patrones_if.sv
// Frame-request / serial-output bundle for generador_patrones.
// The requester (master) offers a payload word and length.
// The pattern generator (slave) shifts the frame out serially.
interface generador_patrones_if;
    logic [7:0] data_in;
    logic [2:0] len_in;
    logic       valid_in;
    logic       ready_out;
    logic       out;
    logic       out_en;
    logic       busy;
    logic       done;

    modport master (
        output data_in,
        output len_in,
        output valid_in,
        input  ready_out,
        input  out,
        input  out_en,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  len_in,
        input  valid_in,
        output ready_out,
        output out,
        output out_en,
        output busy,
        output done
    );
endinterface

// File: rtl/generador_patrones.sv
// Serial frame pattern generator.
// Each frame is: a 4-bit preamble (MSB first), then L = len+1 payload bits
// (MSB first, starting at bit L-1), then GAP_CYCLES idle cycles.
// All outputs are decoded from registered state, so no input reaches an
// output combinationally.
module generador_patrones #(
    parameter logic [3:0]  PREAMBLE   = 4'b1011,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    generador_patrones_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    // Last value of the gap counter before returning to IDLE.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] data_q,  data_d;
    logic [2:0] len_q,   len_d;
    logic [2:0] idx_q,   idx_d;
    logic [3:0] gap_q,   gap_d;

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= 8'd0;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic: accept in IDLE only, then walk preamble, payload, gap.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_in) begin
                    data_d  = bus.data_in;
                    len_d   = bus.len_in;
                    idx_d   = 3'd3;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (idx_q == 3'd0) begin
                    // Payload starts at bit L-1, which equals the captured len.
                    idx_d   = len_q;
                    state_d = S_PAYLOAD;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            S_PAYLOAD: begin
                if (idx_q == 3'd0) begin
                    gap_d   = 4'd0;
                    state_d = S_GAP;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic out_c, out_en_c, done_c;

    // Output decode from the registered state only.
    always_comb begin
        out_c    = 1'b0;
        out_en_c = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            S_PREAMBLE: begin
                // idx never exceeds 3 while in the preamble.
                out_c    = PREAMBLE[idx_q[1:0]];
                out_en_c = 1'b1;
            end
            S_PAYLOAD: begin
                out_c    = data_q[idx_q];
                out_en_c = 1'b1;
            end
            S_GAP: begin
                // Completion is flagged in the first gap cycle only.
                done_c = (gap_q == 4'd0);
            end
            default: begin
                out_c    = 1'b0;
                out_en_c = 1'b0;
                done_c   = 1'b0;
            end
        endcase
    end

    assign bus.out       = out_c;
    assign bus.out_en    = out_en_c;
    assign bus.done      = done_c;
    assign bus.ready_out = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);

endmodule
